// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - RV32I decode stage with registered output, skid buffer and illegal counter
module instr_decode_stage #(
   parameter bit CSR_EN    = 1'b1,
   parameter bit CUSTOM_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instr,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [31:0]      out_imm,
   output logic             out_we,
   output logic [47:0]      out_flags,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] imm;
      logic        we;
      logic [47:0] flags;
      logic        illegal;
   } entry_t;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
   logic [47:0] dec_flags;
   logic [31:0] dec_imm;
   logic        dec_we, dec_illegal, has_rd;
   entry_t      dec_entry;

   entry_t            main_q, main_d, skid_q, skid_d;
   logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept, drain, main_free;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_z  = {20'b0, in_instr[31:20]};

   // Decode the incoming word into a one-hot op, immediate and rd write enable
   always_comb begin
      dec_flags = '0;
      dec_imm   = '0;
      has_rd    = 1'b0;
      case (opcode)
         7'h37: begin dec_flags[0] = 1'b1; dec_imm = imm_u; has_rd = 1'b1; end
         7'h17: begin dec_flags[1] = 1'b1; dec_imm = imm_u; has_rd = 1'b1; end
         7'h6F: begin dec_flags[2] = 1'b1; dec_imm = imm_j; has_rd = 1'b1; end
         7'h67: begin
            dec_imm = imm_i; has_rd = 1'b1;
            if (f3 == 3'd0) dec_flags[3] = 1'b1;
         end
         7'h63: begin
            dec_imm = imm_b;
            case (f3)
               3'd0: dec_flags[4] = 1'b1;
               3'd1: dec_flags[5] = 1'b1;
               3'd4: dec_flags[6] = 1'b1;
               3'd5: dec_flags[7] = 1'b1;
               3'd6: dec_flags[8] = 1'b1;
               3'd7: dec_flags[9] = 1'b1;
               default: ;
            endcase
         end
         7'h03: begin
            dec_imm = imm_i; has_rd = 1'b1;
            case (f3)
               3'd0: dec_flags[10] = 1'b1;
               3'd1: dec_flags[11] = 1'b1;
               3'd2: dec_flags[12] = 1'b1;
               3'd4: dec_flags[13] = 1'b1;
               3'd5: dec_flags[14] = 1'b1;
               default: ;
            endcase
         end
         7'h23: begin
            dec_imm = imm_s;
            case (f3)
               3'd0: dec_flags[15] = 1'b1;
               3'd1: dec_flags[16] = 1'b1;
               3'd2: dec_flags[17] = 1'b1;
               default: ;
            endcase
         end
         7'h13: begin
            dec_imm = imm_i; has_rd = 1'b1;
            case (f3)
               3'd0: dec_flags[18] = 1'b1;
               3'd2: dec_flags[19] = 1'b1;
               3'd3: dec_flags[20] = 1'b1;
               3'd4: dec_flags[21] = 1'b1;
               3'd6: dec_flags[22] = 1'b1;
               3'd7: dec_flags[23] = 1'b1;
               3'd1: if (f7 == 7'h00) dec_flags[24] = 1'b1;
               3'd5: begin
                  if (f7 == 7'h00)      dec_flags[25] = 1'b1;
                  else if (f7 == 7'h20) dec_flags[26] = 1'b1;
               end
               default: ;
            endcase
         end
         7'h33: begin
            has_rd = 1'b1;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: dec_flags[27] = 1'b1;
                  3'd1: dec_flags[29] = 1'b1;
                  3'd2: dec_flags[30] = 1'b1;
                  3'd3: dec_flags[31] = 1'b1;
                  3'd4: dec_flags[32] = 1'b1;
                  3'd5: dec_flags[33] = 1'b1;
                  3'd6: dec_flags[35] = 1'b1;
                  default: dec_flags[36] = 1'b1;
               endcase
            end else if (f7 == 7'h20) begin
               if (f3 == 3'd0)      dec_flags[28] = 1'b1;
               else if (f3 == 3'd5) dec_flags[34] = 1'b1;
            end
         end
         7'h0F: begin
            dec_imm = imm_i;
            if (f3 == 3'd0) dec_flags[37] = 1'b1;
         end
         7'h73: begin
            dec_imm = imm_i;
            if (in_instr == 32'h0000_0073)      dec_flags[38] = 1'b1;
            else if (in_instr == 32'h0010_0073) dec_flags[39] = 1'b1;
            else if (CSR_EN) begin
               if (in_instr == 32'h3020_0073) dec_flags[46] = 1'b1;
               else begin
                  dec_imm = imm_z; has_rd = 1'b1;
                  case (f3)
                     3'd1: dec_flags[40] = 1'b1;
                     3'd2: dec_flags[41] = 1'b1;
                     3'd3: dec_flags[42] = 1'b1;
                     3'd5: dec_flags[43] = 1'b1;
                     3'd6: dec_flags[44] = 1'b1;
                     3'd7: dec_flags[45] = 1'b1;
                     default: ;
                  endcase
               end
            end
         end
         7'h7F: begin
            if (CUSTOM_EN) begin dec_flags[47] = 1'b1; has_rd = 1'b1; end
         end
         default: ;
      endcase
      dec_illegal = ~|dec_flags;
      dec_we      = has_rd & (|in_instr[11:7]) & ~dec_illegal;
      if (dec_illegal) dec_imm = '0;
   end

   assign dec_entry = '{pc: in_pc, instr: in_instr, imm: dec_imm, we: dec_we,
                        flags: dec_flags, illegal: dec_illegal};

   assign in_ready  = ~skid_valid_q;
   assign accept    = in_valid & ~skid_valid_q;
   assign drain     = main_valid_q & out_ready;
   assign main_free = ~main_valid_q | drain;

   // Buffer movement: refill main from skid first, else from input; overflow lands in skid
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (drain && main_q.illegal && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_free) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = accept;
            if (accept) main_d = dec_entry;
         end
      end else if (accept) begin
         skid_d       = dec_entry;
         skid_valid_d = 1'b1;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid   = main_valid_q;
   assign out_pc      = main_q.pc;
   assign out_instr   = main_q.instr;
   assign out_rd      = main_q.instr[11:7];
   assign out_rs1     = main_q.instr[19:15];
   assign out_rs2     = main_q.instr[24:20];
   assign out_imm     = main_q.imm;
   assign out_we      = main_q.we;
   assign out_flags   = main_q.flags;
   assign out_illegal = main_q.illegal;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_instr;

   logic d0_in_ready, d0_out_valid, d0_out_we, d0_out_illegal;
   logic [31:0] d0_out_pc, d0_out_instr, d0_out_imm;
   logic [4:0]  d0_out_rd, d0_out_rs1, d0_out_rs2;
   logic [47:0] d0_out_flags;
   logic [15:0] d0_cnt;

   logic d1_in_ready, d1_out_valid, d1_out_we, d1_out_illegal;
   logic [31:0] d1_out_pc, d1_out_instr, d1_out_imm;
   logic [4:0]  d1_out_rd, d1_out_rs1, d1_out_rs2;
   logic [47:0] d1_out_flags;
   logic [15:0] d1_cnt;

   logic d2_in_ready, d2_out_valid, d2_out_we, d2_out_illegal;
   logic [31:0] d2_out_pc, d2_out_instr, d2_out_imm;
   logic [4:0]  d2_out_rd, d2_out_rs1, d2_out_rs2;
   logic [47:0] d2_out_flags;
   logic [1:0]  d2_cnt;

   instr_decode_stage dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(d0_out_valid), .out_ready(out_ready),
      .out_pc(d0_out_pc), .out_instr(d0_out_instr), .out_rd(d0_out_rd), .out_rs1(d0_out_rs1),
      .out_rs2(d0_out_rs2), .out_imm(d0_out_imm), .out_we(d0_out_we), .out_flags(d0_out_flags),
      .out_illegal(d0_out_illegal), .illegal_cnt(d0_cnt));

   instr_decode_stage #(.CSR_EN(1'b0), .CUSTOM_EN(1'b0)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(d1_out_valid), .out_ready(out_ready),
      .out_pc(d1_out_pc), .out_instr(d1_out_instr), .out_rd(d1_out_rd), .out_rs1(d1_out_rs1),
      .out_rs2(d1_out_rs2), .out_imm(d1_out_imm), .out_we(d1_out_we), .out_flags(d1_out_flags),
      .out_illegal(d1_out_illegal), .illegal_cnt(d1_cnt));

   instr_decode_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(d2_out_valid), .out_ready(out_ready),
      .out_pc(d2_out_pc), .out_instr(d2_out_instr), .out_rd(d2_out_rd), .out_rs1(d2_out_rs1),
      .out_rs2(d2_out_rs2), .out_imm(d2_out_imm), .out_we(d2_out_we), .out_flags(d2_out_flags),
      .out_illegal(d2_out_illegal), .illegal_cnt(d2_cnt));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ISA encoding table: a word is op k when (word & mask) == match
   logic [31:0] pat_mask [48];
   logic [31:0] pat_match [48];

   task automatic setp(input int i, input logic [31:0] m, input logic [31:0] v);
      pat_mask[i] = m;
      pat_match[i] = v;
   endtask

   task automatic init_patterns();
      logic [31:0] bf3 [6] = '{0, 1, 4, 5, 6, 7};
      logic [31:0] lf3 [5] = '{0, 1, 2, 4, 5};
      logic [31:0] if3 [6] = '{0, 2, 3, 4, 6, 7};
      logic [31:0] cf3 [6] = '{1, 2, 3, 5, 6, 7};
      logic [31:0] rop [10] = '{32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
                                32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};
      setp(0, 32'h7F, 32'h37);
      setp(1, 32'h7F, 32'h17);
      setp(2, 32'h7F, 32'h6F);
      setp(3, 32'h707F, 32'h67);
      for (int i = 0; i < 6; i++) setp(4 + i, 32'h707F, 32'h63 | (bf3[i] << 12));
      for (int i = 0; i < 5; i++) setp(10 + i, 32'h707F, 32'h03 | (lf3[i] << 12));
      for (int i = 0; i < 3; i++) setp(15 + i, 32'h707F, 32'h23 | (i << 12));
      for (int i = 0; i < 6; i++) setp(18 + i, 32'h707F, 32'h13 | (if3[i] << 12));
      setp(24, 32'hFE00707F, 32'h1013);
      setp(25, 32'hFE00707F, 32'h5013);
      setp(26, 32'hFE00707F, 32'h40005013);
      for (int i = 0; i < 10; i++) setp(27 + i, 32'hFE00707F, rop[i]);
      setp(37, 32'h707F, 32'h0F);
      setp(38, 32'hFFFFFFFF, 32'h73);
      setp(39, 32'hFFFFFFFF, 32'h00100073);
      for (int i = 0; i < 6; i++) setp(40 + i, 32'h707F, 32'h73 | (cf3[i] << 12));
      setp(46, 32'hFFFFFFFF, 32'h30200073);
      setp(47, 32'h7F, 32'h7F);
   endtask

   function automatic void ref_decode(input logic [31:0] ins, input bit csr_en, input bit cust_en,
                                      output logic [47:0] fl, output logic [31:0] imm,
                                      output logic we, output logic ill);
      int k;
      k = -1;
      for (int i = 0; i < 48; i++)
         if ((ins & pat_mask[i]) == pat_match[i])
            if (!((i >= 40 && i <= 46 && !csr_en) || (i == 47 && !cust_en))) k = i;
      fl = '0; imm = '0; we = 1'b0; ill = (k < 0);
      if (k >= 0) begin
         fl[k] = 1'b1;
         if (k <= 1)                   imm = ins & 32'hFFFFF000;
         else if (k == 2)              imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         else if (k >= 4 && k <= 9)    imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         else if (k >= 15 && k <= 17)  imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         else if (k >= 40 && k <= 45)  imm = ins >> 20;
         else if ((k >= 27 && k <= 36) || k == 47) imm = '0;
         else                          imm = $unsigned($signed(ins) >>> 20);
         we = (ins[11:7] != 5'd0) &&
              !((k >= 4 && k <= 9) || (k >= 15 && k <= 17) || (k >= 37 && k <= 39) || k == 46);
      end
   endfunction

   function automatic logic [31:0] gen_instr();
      int r;
      int k;
      r = $urandom_range(0, 9);
      if (r == 0) return 32'h0;
      if (r == 1) return $urandom;
      k = $urandom_range(0, 47);
      return ($urandom & ~pat_mask[k]) | pat_match[k];
   endfunction

   typedef struct {
      logic [31:0] instr;
      int          idx;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        we;
      logic        gated;
   } vec_t;

   typedef struct {
      logic [31:0] pc, instr, imm;
      logic [47:0] flags;
      logic        we, ill;
   } exp_t;

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      vec_t        vecs [17];
      exp_t        q [$];
      exp_t        e;
      logic [31:0] bp_list [4];
      logic [31:0] rcv [$];
      logic [47:0] one, ef;
      int          idx, mcnt, m2cnt;
      bit          acc, drn;

      vecs[0]  = '{32'h00000797, 1,  5'd15, 5'd0,  5'd0,  32'h0,        1'b1, 1'b0};
      vecs[1]  = '{32'h02c78793, 18, 5'd15, 5'd15, 5'd12, 32'd44,       1'b1, 1'b0};
      vecs[2]  = '{32'h1a5000ef, 2,  5'd1,  5'd0,  5'd5,  32'h9A4,      1'b1, 1'b0};
      vecs[3]  = '{32'h00112623, 17, 5'd12, 5'd2,  5'd1,  32'd12,       1'b0, 1'b0};
      vecs[4]  = '{32'h04079263, 5,  5'd4,  5'd15, 5'd0,  32'h44,       1'b0, 1'b0};
      vecs[5]  = '{32'h07f56513, 22, 5'd10, 5'd10, 5'd31, 32'd127,      1'b1, 1'b0};
      vecs[6]  = '{32'h305793f3, 40, 5'd7,  5'd15, 5'd5,  32'h305,      1'b1, 1'b1};
      vecs[7]  = '{32'h30200073, 46, 5'd0,  5'd0,  5'd2,  32'h302,      1'b0, 1'b1};
      vecs[8]  = '{32'h8000007F, 47, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 1'b1};
      vecs[9]  = '{32'h00000000, -1, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0};
      vecs[10] = '{32'h00000073, 38, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0};
      vecs[11] = '{32'h00100073, 39, 5'd0,  5'd0,  5'd1,  32'h1,        1'b0, 1'b0};
      vecs[12] = '{32'hfff00093, 18, 5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[13] = '{32'h40515513, 26, 5'd10, 5'd2,  5'd5,  32'h405,      1'b1, 1'b0};
      vecs[14] = '{32'h40511513, -1, 5'd10, 5'd2,  5'd5,  32'h0,        1'b0, 1'b0};
      vecs[15] = '{32'h002081b3, 27, 5'd3,  5'd1,  5'd2,  32'h0,        1'b1, 1'b0};
      vecs[16] = '{32'h402081b3, 28, 5'd3,  5'd1,  5'd2,  32'h0,        1'b1, 1'b0};
      bp_list = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
      one = 48'd1;
      init_patterns();

      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("reset_out_valid", d0_out_valid, 0);
      check("reset_in_ready", d0_in_ready, 1);
      check("reset_cnt", d0_cnt, 0);
      check("reset_flags", d0_out_flags, 0);
      rst = 1'b0;

      // Single-instruction decode table
      out_ready = 1'b1; in_pc = 32'h02000020;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_instr = vecs[i].instr;
         @(posedge clk); #1;
         in_valid = 1'b0;
         ef = (vecs[i].idx < 0) ? 48'd0 : (one << vecs[i].idx);
         check($sformatf("vec%0d_valid", i), d0_out_valid, 1);
         check($sformatf("vec%0d_flags", i), d0_out_flags, ef);
         check($sformatf("vec%0d_illegal", i), d0_out_illegal, vecs[i].idx < 0);
         check($sformatf("vec%0d_rd", i), d0_out_rd, vecs[i].rd);
         check($sformatf("vec%0d_rs1", i), d0_out_rs1, vecs[i].rs1);
         check($sformatf("vec%0d_rs2", i), d0_out_rs2, vecs[i].rs2);
         check($sformatf("vec%0d_imm", i), d0_out_imm, vecs[i].imm);
         check($sformatf("vec%0d_we", i), d0_out_we, vecs[i].we);
         check($sformatf("vec%0d_pc", i), d0_out_pc, 32'h02000020);
         check($sformatf("vec%0d_gated_flags", i), d1_out_flags, vecs[i].gated ? 48'd0 : ef);
         check($sformatf("vec%0d_gated_illegal", i), d1_out_illegal,
               vecs[i].gated || (vecs[i].idx < 0));
      end

      // Illegal counting and saturation at CNT_W=2
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0;
      @(posedge clk); #1;
      check("ill_valid", d0_out_valid, 1);
      check("ill_flag", d0_out_illegal, 1);
      @(posedge clk); @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("ill_cnt3", d0_cnt, 3);
      check("ill_cnt3_w2", d2_cnt, 3);
      in_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("ill_cnt5", d0_cnt, 5);
      check("ill_sat_w2", d2_cnt, 3);

      // Backpressure: two accepts fill the buffer, then everything drains in order
      do_reset();
      idx = 0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_instr = bp_list[idx];
         @(negedge clk);
         acc = d0_in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      check("bp_accepts", idx, 2);
      check("bp_in_ready_low", d0_in_ready, 0);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && rcv.size() < 4; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) in_instr = bp_list[idx];
         @(negedge clk);
         acc = in_valid && d0_in_ready;
         if (d0_out_valid) rcv.push_back(d0_out_instr);
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      check("bp_count", rcv.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("bp_order%0d", i), (i < rcv.size()) ? rcv[i] : 32'hDEADBEEF, bp_list[i]);
      @(posedge clk); #1;
      check("bp_no_dup", d0_out_valid, 0);

      // Flush with both entries full, draining an illegal entry in the same cycle
      do_reset();
      in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h200;
      @(posedge clk); #1;
      in_instr = 32'h00500093; in_pc = 32'h204;
      @(posedge clk); #1;
      check("fl_full_ready", d0_in_ready, 0);
      check("fl_full_valid", d0_out_valid, 1);
      flush = 1'b1; out_ready = 1'b1; in_instr = 32'h00700093;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("fl_valid", d0_out_valid, 0);
      check("fl_ready", d0_in_ready, 1);
      check("fl_cnt", d0_cnt, 1);
      in_valid = 1'b1; in_instr = 32'h00900093; in_pc = 32'h300;
      @(posedge clk); #1;
      check("fl2_ready", d0_in_ready, 1);
      check("fl2_valid", d0_out_valid, 1);
      flush = 1'b1; in_instr = 32'h00b00093; in_pc = 32'h304;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("fl2_dropped%0d", c), d0_out_valid, 0);
         @(posedge clk); #1;
      end

      // Randomised traffic against a queue model
      do_reset();
      q.delete(); mcnt = 0; m2cnt = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_instr  = gen_instr();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         check("rnd_valid", d0_out_valid, q.size() > 0);
         check("rnd_ready", d0_in_ready, q.size() < 2);
         check("rnd_cnt", d0_cnt, mcnt);
         check("rnd_cnt_w2", d2_cnt, m2cnt);
         if (q.size() > 0) begin
            check("rnd_pc", d0_out_pc, q[0].pc);
            check("rnd_instr", d0_out_instr, q[0].instr);
            check("rnd_flags", d0_out_flags, q[0].flags);
            check("rnd_imm", d0_out_imm, q[0].imm);
            check("rnd_we", d0_out_we, q[0].we);
            check("rnd_illegal", d0_out_illegal, q[0].ill);
            check("rnd_rd", d0_out_rd, q[0].instr[11:7]);
         end
         acc = in_valid && (q.size() < 2);
         drn = (q.size() > 0) && out_ready;
         if (drn && q[0].ill) begin
            if (mcnt < 65535) mcnt++;
            if (m2cnt < 3) m2cnt++;
         end
         if (flush) q.delete();
         else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
               e.pc = in_pc; e.instr = in_instr;
               ref_decode(in_instr, 1'b1, 1'b1, e.flags, e.imm, e.we, e.ill);
               q.push_back(e);
            end
         end
         @(posedge clk); #1;
      end
      flush = 1'b0;

      // Asynchronous reset between edges with both entries occupied
      do_reset();
      in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h0; in_pc = 32'h100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_instr = 32'h00100093; in_pc = 32'h104;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("ar_pre_cnt", d0_cnt, 1);
      check("ar_pre_ready", d0_in_ready, 0);
      #2 rst = 1'b1;
      #1;
      check("ar_valid", d0_out_valid, 0);
      check("ar_ready", d0_in_ready, 1);
      check("ar_pc", d0_out_pc, 0);
      check("ar_instr", d0_out_instr, 0);
      check("ar_flags", d0_out_flags, 0);
      check("ar_imm", d0_out_imm, 0);
      check("ar_we", d0_out_we, 0);
      check("ar_illegal", d0_out_illegal, 0);
      check("ar_cnt", d0_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV32I instruction-decode pipeline stage. It sits between instruction fetch and execute and accepts one `{pc, instruction}` per cycle over a valid/ready handshake. It decodes each instruction into a 48-bit one-hot operation vector, register indices, a sign-extended immediate and an illegal flag. A two-entry skid buffer decouples upstream and downstream stalls, a flush input squashes in-flight entries, and a saturating counter tracks illegal instructions.

## Interface
- `CSR_EN`, 1: decode the CSR group (indices 40–45) and MRET (46); when 0 these encodings are illegal.
- `CUSTOM_EN`, 1: decode opcode 7'h7F as CUSTOM (47); when 0 it is illegal.
- `CNT_W`, 16: width of the illegal-instruction counter.
- `clk`  in  1  clock. Everything samples on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  squashes both buffer entries.
- `in_valid` in 1; `in_ready` out 1; `in_pc` in 32; `in_instr` in 32: upstream handshake and payload.
- `out_valid` in/out: `out_valid` out 1; `out_ready` in 1: downstream handshake.
- `out_pc` out 32; `out_instr` out 32: pass-through of the accepted payload.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each: the raw instruction fields [11:7], [19:15], [24:20].
- `out_imm`  out  32: sign-extended immediate for the format; CSR address (zero-extended) for CSR ops; 0 for R-type.
- `out_we`  out  1: rd write enable. It is 0 when rd=0 or when the op has no rd.
- `out_flags`  out  48: one-hot operation index. All zero when illegal.
- `out_illegal`  out  1: no legal decode.
- `illegal_cnt`  out  CNT_W: count of illegal instructions delivered downstream, saturating.

## Operation
- Flag index map:
  - LUI 0, AUIPC 1, JAL 2, JALR 3
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: 4–9
  - LB, LH, LW, LBU, LHU: 10–14
  - SB, SH, SW: 15–17
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI: 18–26
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: 27–36
  - FENCE 37, ECALL 38, EBREAK 39
  - CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI: 40–45
  - MRET 46, CUSTOM 47
- Decode requirements:
  - Full match on opcode, funct3 and funct7 where the ISA defines them.
  - SLLI/SRLI/SRAI additionally require funct7 = 0000000 or 0100000 as appropriate.
  - ECALL, EBREAK and MRET require an exact 32-bit match.
  - Any other encoding, including 32'h0, sets `out_illegal`=1 and leaves `out_flags`=0.
- Immediate formats: I, S, B, U and J per the RV32I spec. The B and J immediates have bit 0 = 0.
- Decode is combinational on the input and is registered into the entry, so the outputs are always registered.
- Buffer structure: a main output register plus one skid register.
- `in_ready` = skid empty. It is registered and does not combinationally depend on `out_ready`.
- Accept occurs when `in_valid & in_ready`. The decoded entry goes to main if main is empty or draining this cycle; otherwise it goes to skid.
- Drain occurs when `out_valid & out_ready`. On drain, skid moves to main if skid is occupied.
- The payload is held stable while `out_valid & !out_ready`.
- `illegal_cnt` increments on a drain of an entry with `out_illegal`=1 and saturates at all ones.
- Flush:
  - Clears both entries at the clock edge; `in_ready`=1 the next cycle.
  - An input presented in the flush cycle is dropped.
  - A drain coinciding with flush still counts toward `illegal_cnt`.
  - The counter itself is not cleared by flush.

## Timing
- Latency: an accept at edge N makes `out_valid`=1 after edge N.
- Throughput: 1 instruction/cycle when `out_ready` is held at 1.
- Reset values, asynchronous on `rst`:
  - `out_valid`=0, `in_ready`=1
  - all payload outputs 0, `out_illegal`=0, `illegal_cnt`=0
- Reset mid-transfer discards both entries without a drain.
- Both entries full: `in_ready`=0. A drain frees skid, and `in_ready`=1 from the next cycle.
- Simultaneous accept and drain with skid empty: main is replaced and no bubble is inserted.

## Test plan
- **Single instructions**, `out_ready`=1 and `in_pc`=0x02000020, each must produce the listed fields one cycle later:
  - 32'h00000797: flags bit 1, rd=15, imm=0, we=1.
  - 32'h02c78793: bit 18, rd=15, rs1=15, imm=44.
  - 32'h1a5000ef: bit 2, rd=1, imm=0x9A4.
  - 32'h00112623: bit 17, rs1=2, rs2=1, imm=12, we=0.
  - 32'h04079263: bit 5, rs1=15, rs2=0, imm=0x44.
  - 32'h07f56513: bit 22, rd=10, imm=127.
- **System and custom ops:** 32'h305793f3 -> bit 40, rd=7, rs1=15, imm=0x305; 32'h30200073 -> bit 46, we=0; 32'h8000007F -> bit 47. Repeat with `CSR_EN`=`CUSTOM_EN`=0 -> all three illegal with flags 0.
- **Illegal counting:** 32'h0 delivered 3 times -> `out_illegal`=1, `illegal_cnt`=3. With `CNT_W`=2, 5 illegal instructions -> count holds at 3.
- **Backpressure:** stream 4 instructions with `out_ready`=0 -> `in_ready` falls after 2 accepts. Then `out_ready`=1 -> all 4 emerge in order, none lost or duplicated.
- **Flush:** flush with both entries full -> `out_valid`=0 and `in_ready`=1 next cycle. The instruction presented in the flush cycle never appears at the output.
- **Reset:** assert `rst` mid-stream, asynchronously between edges -> all outputs take their reset values immediately.
